// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants and types for the SHA-256 message padder.
//   SHA_BLOCK_WORDS : 32-bit words per 512-bit block
//   PAD_MARKER      : byte appended right after the last message byte
//   LEN_FIELD_W     : width of the trailing message-length field in bits
//   PAD_LAST_IDX    : last word index of zero fill before the length words
//   pad_state_e     : padder sequencing states
package sha256_msg_padder_pkg;

  localparam int unsigned SHA_BLOCK_WORDS = 16;
  localparam logic [7:0]  PAD_MARKER      = 8'h80;
  localparam int unsigned LEN_FIELD_W     = 64;
  localparam logic [3:0]  PAD_LAST_IDX    = 4'(SHA_BLOCK_WORDS - 3);

  typedef enum logic [1:0] {
    StData,
    StPadz,
    StLenHi,
    StLenLo
  } pad_state_e;

endpackage

// File: rtl/sha256_word_asm.sv
// Byte-to-word assembler with end-of-message marker insertion.
// Collects up to three bytes and completes a big-endian word on the fourth
// byte, or early on the final byte of a message by appending the 0x80 marker
// and zero fill.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clr_i         : discard any partially assembled bytes
//   push_i        : byte_i is accepted this cycle
//   last_i        : the accepted byte ends the message
//   byte_i        : message byte
//   word_o        : completed word (meaningful when done_o is high)
//   done_o        : a word is completed this cycle
//   mark_pend_o   : final byte filled the word; the marker needs a word of its own
module sha256_word_asm
  import sha256_msg_padder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic        last_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o,
  output logic        mark_pend_o
);

  logic [23:0] asm_q, asm_d;
  logic [1:0]  pos_q, pos_d;

  // Bytes already held occupy the upper lanes; the marker follows the new byte.
  always_comb begin
    word_o = '0;
    case (pos_q)
      2'd0:    word_o = {byte_i, PAD_MARKER, 16'h0000};
      2'd1:    word_o = {asm_q[7:0], byte_i, PAD_MARKER, 8'h00};
      2'd2:    word_o = {asm_q[15:0], byte_i, PAD_MARKER};
      default: word_o = {asm_q, byte_i};
    endcase
  end

  assign done_o      = push_i && (last_i || (pos_q == 2'd3));
  assign mark_pend_o = push_i && last_i && (pos_q == 2'd3);

  always_comb begin
    asm_d = asm_q;
    pos_d = pos_q;
    if (clr_i || done_o) begin
      asm_d = '0;
      pos_d = '0;
    end else if (push_i) begin
      asm_d = {asm_q[15:0], byte_i};
      pos_d = pos_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q <= '0;
      pos_q <= '0;
    end else begin
      asm_q <= asm_d;
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message padder: turns a byte stream into padded 512-bit
// blocks emitted as sixteen big-endian 32-bit words, with 0x80 marker, zero
// fill and a 64-bit big-endian bit-length trailer.
// Optional feature: define SHA_PAD_OVF_ERR_EN to add the sticky ovf_err
// output, flagged when the byte counter wraps.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_byte/in_valid/in_last/in_ready : byte input handshake, in_last marks final byte
//   out_word/out_idx      : message word and its index within the block
//   out_blk_last          : high with word 15 of the message's final block
//   out_valid/out_ready   : word output handshake
//   ovf_err               : (optional) byte counter overflowed, sticky until reset
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_idx,
  output logic        out_blk_last,
  output logic        out_valid,
  input  logic        out_ready
`ifdef SHA_PAD_OVF_ERR_EN
  ,
  output logic        ovf_err
`endif
);

  pad_state_e state_q, state_d;

  logic [LEN_W-1:0]       cnt_q;
  logic [3:0]             widx_q;
  logic                   mark_q;
  logic [31:0]            out_word_q;
  logic [3:0]             out_idx_q;
  logic                   out_blk_last_q;
  logic                   out_valid_q;

  logic                   slot_free;
  logic                   byte_acc;
  logic                   load;
  logic [31:0]            load_word;
  logic [LEN_FIELD_W-1:0] len_bits;

  logic [31:0] asm_word;
  logic        asm_done;
  logic        asm_mark_pend;

  // Output register may be refilled in the same cycle it is drained.
  assign slot_free = !out_valid_q || out_ready;
  assign byte_acc  = in_valid && in_ready;
  assign len_bits  = {{(LEN_FIELD_W - LEN_W - 3){1'b0}}, cnt_q, 3'b000};

  sha256_word_asm u_word_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (load && (state_q == StLenLo)),
    .push_i      (byte_acc),
    .last_i      (in_last),
    .byte_i      (in_byte),
    .word_o      (asm_word),
    .done_o      (asm_done),
    .mark_pend_o (asm_mark_pend)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StData;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StData: begin
        if (byte_acc && in_last) begin
          // Marker word at index 13 leaves exactly room for the length words.
          if (!asm_mark_pend && (widx_q == PAD_LAST_IDX)) begin
            state_d = StLenHi;
          end else begin
            state_d = StPadz;
          end
        end
      end
      StPadz: begin
        if (slot_free && (widx_q == PAD_LAST_IDX)) state_d = StLenHi;
      end
      StLenHi: begin
        if (slot_free) state_d = StLenLo;
      end
      StLenLo: begin
        if (slot_free) state_d = StData;
      end
      default: state_d = StData;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = 1'b0;
    load      = 1'b0;
    load_word = '0;
    case (state_q)
      StData: begin
        in_ready  = slot_free;
        load      = asm_done;
        load_word = asm_word;
      end
      StPadz: begin
        load      = slot_free;
        load_word = mark_q ? {PAD_MARKER, 24'h000000} : 32'h0000_0000;
      end
      StLenHi: begin
        load      = slot_free;
        load_word = len_bits[63:32];
      end
      StLenLo: begin
        load      = slot_free;
        load_word = len_bits[31:0];
      end
      default: ;
    endcase
  end

  // Datapath: byte counter, word index, pending marker, output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      widx_q         <= '0;
      mark_q         <= 1'b0;
      out_word_q     <= '0;
      out_idx_q      <= '0;
      out_blk_last_q <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      if (load && (state_q == StLenLo)) begin
        cnt_q <= '0;
      end else if (byte_acc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end

      if (byte_acc && asm_mark_pend) begin
        mark_q <= 1'b1;
      end else if (load && (state_q == StPadz)) begin
        mark_q <= 1'b0;
      end

      if (load) begin
        widx_q         <= widx_q + 4'd1;
        out_word_q     <= load_word;
        out_idx_q      <= widx_q;
        out_blk_last_q <= (state_q == StLenLo);
        out_valid_q    <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef SHA_PAD_OVF_ERR_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (byte_acc && (&cnt_q)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

  assign out_word     = out_word_q;
  assign out_idx      = out_idx_q;
  assign out_blk_last = out_blk_last_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: directed and random messages
// compared against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic [3:0]  out_idx;
  logic        out_blk_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef SHA_PAD_OVF_ERR_EN
  logic        ovf_err;
`endif

  int total = 0;
  int bad = 0;

  byte unsigned msg_q[$];
  logic [36:0]  exp_q[$];
  logic [36:0]  got_q[$];

  always #5 clk = ~clk;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_word     (out_word),
    .out_idx      (out_idx),
    .out_blk_last (out_blk_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef SHA_PAD_OVF_ERR_EN
    ,
    .ovf_err      (ovf_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: pad the byte message, then slice into {word, idx, blk_last}.
  function automatic void build_exp();
    byte unsigned pad[$];
    logic [63:0]  bits;
    int           nw;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    nw = pad.size() / 4;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({pad[4*i], pad[4*i+1], pad[4*i+2], pad[4*i+3], 4'(i % 16), (i == nw - 1)});
    end
  endfunction

  function automatic logic [31:0] got_word(input int i);
    logic [36:0] e;
    e = got_q[i];
    return e[36:5];
  endfunction

  function automatic logic [4:0] got_tail(input int i);
    logic [36:0] e;
    e = got_q[i];
    return e[4:0];
  endfunction

  task automatic set_seq(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
  endtask

  task automatic set_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // stall: 0 = always ready, 1 = toggle each cycle, 2 = random; gaps: random in_valid drops
  task automatic run_msg(input string tag, input int stall, input int gaps);
    int          ptr;
    int          cyc;
    bit          hold;
    logic [35:0] held;
    ptr  = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    got_q.delete();
    build_exp();
    while (got_q.size() < exp_q.size() && cyc < 4000) begin
      @(negedge clk);
      if (hold) begin
        chk({tag, "/stall_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/stall_hold"}, 64'({out_word, out_idx}), 64'(held));
      end
      case (stall)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (ptr < msg_q.size() && (gaps == 0 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_byte  = msg_q[ptr];
        in_last  = (ptr == msg_q.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom_range(0, 1));
      end
      #1;
      if (out_valid && out_ready) got_q.push_back({out_word, out_idx, out_blk_last});
      hold = out_valid && !out_ready;
      held = {out_word, out_idx};
      if (in_valid && in_ready) ptr++;
      cyc++;
    end
    chk({tag, "/nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, "/bytes_taken"}, 64'(ptr), 64'(msg_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s/w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk({tag, "/idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "/out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "/out_word"}, 64'(out_word), 64'd0);
    chk({tag, "/out_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "/blk_last"}, 64'(out_blk_last), 64'd0);
    chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("rst");

    // "abc"
    set_abc();
    run_msg("abc", 0, 0);
    chk("abc/w0_lit", 64'(got_word(0)), 64'h6162_6380);
    chk("abc/w14_lit", 64'(got_word(14)), 64'h0);
    chk("abc/w15_lit", 64'(got_word(15)), 64'h18);
    chk("abc/w15_tail", 64'(got_tail(15)), 64'h1F);

    // 55 bytes: single block
    set_seq(55);
    run_msg("b55", 0, 0);
    chk("b55/w13_lit", 64'(got_word(13)), 64'h3435_3680);
    chk("b55/w15_lit", 64'(got_word(15)), 64'h1B8);

    // 56 bytes: two blocks
    set_seq(56);
    run_msg("b56", 0, 0);
    chk("b56/w14_lit", 64'(got_word(14)), 64'h8000_0000);
    chk("b56/w15_last", 64'(got_tail(15)), 64'h1E);
    chk("b56/w31_lit", 64'(got_word(31)), 64'h1C0);
    chk("b56/w31_last", 64'(got_tail(31)), 64'h1F);

    // 64 bytes: marker in its own word at idx 0 of block 1
    set_seq(64);
    run_msg("b64", 0, 0);
    chk("b64/w16_lit", 64'(got_word(16)), 64'h8000_0000);
    chk("b64/w16_idx", 64'(got_tail(16)), 64'h0);
    chk("b64/w31_lit", 64'(got_word(31)), 64'h200);

    // "abc" with out_ready toggling
    set_abc();
    run_msg("abc_tog", 1, 0);

    // Reset in the middle of a message, then "abc"
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h11;
    in_last  = 1'b0;
    @(negedge clk);
    in_byte  = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("midrst");
    set_abc();
    run_msg("abc_after_rst", 0, 0);
    chk("abc_after_rst/w0_lit", 64'(got_word(0)), 64'h6162_6380);

    // Boundary lengths around the marker/length placement, random back-pressure
    set_seq(52);
    run_msg("b52", 2, 1);
    set_seq(60);
    run_msg("b60", 2, 1);
    set_seq(63);
    run_msg("b63", 2, 0);

    // Random messages
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 140);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d", t), 2, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Streaming SHA-256 message pre-processor that turns an arbitrary-length byte message into padded 512-bit blocks presented as sixteen big-endian 32-bit words per block. It sits upstream of the round/iteration core and feeds the 16-entry message-word schedule input (word index 0..15) that the round logic consumes. It replaces the static file-loaded message with a live, back-pressured source. Padding follows FIPS 180-4: 0x80 marker, zero fill, 64-bit big-endian bit length.

## Interface
- LEN_W, 32: width of internal byte counter; max message = 2^LEN_W − 1 bytes.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_byte  in  8  message byte.
- in_valid  in  1  in_byte valid.
- in_last  in  1  qualifies final byte of message (messages ≥ 1 byte).
- in_ready  out  1  padder accepts byte when in_valid && in_ready.
- out_word  out  32  message word, big-endian (first byte in [31:24]).
- out_idx  out  4  word index within block, 0..15.
- out_blk_last  out  1  high with idx 15 of the message's final block.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.

## Operation
- States: DATA (collecting bytes), PADZ (emitting zero words), LEN_HI, LEN_LO, back to DATA.
- DATA: bytes shift into 24-bit assembler; byte counter increments per accepted byte (LEN_W bits). 4th byte loads {asm, byte} into output register with current idx.
- Final byte (in_last): word completed immediately with 0x80 at next byte position, zeros after (e.g. 1 byte b → {b,80,00,00}; 3 bytes → {b0,b1,b2,80}). If final byte fills the word, that word is data only and the next word is 0x80000000.
- After the marker word: PADZ emits zero words until idx 13 has been emitted, then LEN_HI, LEN_LO. If the marker word lands at idx 14 or 15, PADZ fills to idx 15, wraps idx to 0, fills 0..13 of an extra block.
- Length = byte_count × 8, zero-extended to 64 bits; LEN_HI = bits[63:32], LEN_LO = bits[31:0]. Counter and assembler clear after LEN_LO is accepted.
- idx increments on every accepted word, wraps 15→0 modulo 16.
- in_ready low in PADZ/LEN_HI/LEN_LO and whenever the output register is full and not being drained this cycle.

## Timing
- Reset values: out_valid 0, out_word 0, out_idx 0, out_blk_last 0, in_ready 1 (after reset, DATA state), counter 0.
- Word latency: word registered on the edge accepting its 4th (or last) byte; out_valid high the following cycle.
- Single output register; drain-and-refill same cycle permitted → sustained 1 byte/cycle input, 1 word/cycle during padding.
- out_word/out_idx held stable while out_valid && !out_ready.
- Reset mid-message: all partial state discarded, next accepted byte starts a new message at idx 0.
- in_last on a byte not accepted (in_ready low) has no effect.

## Configuration
- SHA_PAD_OVF_ERR_EN defined: adds output `ovf_err` (1 bit, reset 0); set sticky when byte counter would wrap past 2^LEN_W − 1; subsequent bytes still accepted, length field uses wrapped count; cleared only by reset.
- Undefined: no ovf_err port; counter wraps silently.

## Structure
- Shared sha256 package: constants SHA_BLOCK_WORDS=16, PAD_MARKER=8'h80, LEN_FIELD_W=64, state enum typedef.
- One sub-module natural: sha256_word_asm (byte→word assembler with marker insertion); FSM, counter, output register stay in top.

## Test plan
- "abc" (0x61,0x62,0x63, last) → 16 words: 0x61626380, 13× 0x00000000, 0x00000000, 0x00000018; blk_last on idx 15.
- 55 bytes 0x00..0x36 → single block, word 13 = 0x34353680, words 14/15 = 0, 0x000001B8.
- 56 bytes → two blocks; block0 word 14 = 0x80000000, word 15 = 0; block1 words 0..13 zero, word15 = 0x000001C0, blk_last only on block1 idx 15.
- 64 bytes → block1 word0 = 0x80000000, word15 = 0x00000200; idx wraps 15→0.
- "abc" with out_ready toggling 1/0 each cycle → identical word sequence, out_word stable while stalled, no byte lost.
- rst_n low 1 cycle after 2 bytes of a message, then "abc" → output identical to first test.
